// File: rtl/line_burst_adaptor.sv
// Bridges a wide cache line port to a narrow burst memory port: read fills and writebacks.
// Optional critical-word-first reads: define LINE_BURST_ADAPTOR_CRIT_WORD_FIRST_EN.
module line_burst_adaptor #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  // cache side
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  // memory side
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned num_beats  = s_line / s_burst;
  localparam int unsigned BeatW      = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam int unsigned LineBytes  = s_line / 8;
  localparam int unsigned BurstBytes = s_burst / 8;
  localparam int unsigned OffLo      = $clog2(BurstBytes);
  localparam logic [31:0] LineMask   = ~(LineBytes - 1);
  localparam logic [31:0] BurstMask  = ~(BurstBytes - 1);

  typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

  state_e             state_q;
  logic [BeatW-1:0]   beat_q;
  logic [BeatW-1:0]   cnt_q;
  logic [s_line-1:0]  buf_q;

  logic [BeatW-1:0]   beat_nxt;
  logic               last_beat;
  logic [BeatW-1:0]   rd_start;
  logic [31:0]        rd_addr;

  // beat_q is the line offset being transferred; cnt_q counts accepted beats,
  // which differ only when a read starts mid-line.
  assign beat_nxt  = beat_q + BeatW'(1);
  assign last_beat = (cnt_q == BeatW'(num_beats - 1));

`ifdef LINE_BURST_ADAPTOR_CRIT_WORD_FIRST_EN
  assign rd_start = BeatW'(address_i >> OffLo);
  assign rd_addr  = address_i & BurstMask;
`else
  assign rd_start = '0;
  assign rd_addr  = address_i & LineMask;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          resp_o <= 1'b0;
          // Write has priority; a concurrent read is picked up on a later pass through idle.
          if (write_i) begin
            buf_q     <= line_i;
            address_o <= address_i & LineMask;
            beat_q    <= '0;
            cnt_q     <= '0;
            burst_o   <= line_i[s_burst-1:0];
            write_o   <= 1'b1;
            state_q   <= StWrBurst;
          end else if (read_i) begin
            address_o <= rd_addr;
            beat_q    <= rd_start;
            cnt_q     <= '0;
            read_o    <= 1'b1;
            state_q   <= StRdBurst;
          end
        end

        StRdBurst: begin
          if (resp_i) begin
            line_o[s_burst*beat_q +: s_burst] <= burst_i;
            beat_q <= beat_nxt;
            cnt_q  <= cnt_q + BeatW'(1);
            if (last_beat) begin
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        StWrBurst: begin
          if (resp_i) begin
            beat_q  <= beat_nxt;
            cnt_q   <= cnt_q + BeatW'(1);
            burst_o <= buf_q[s_burst*beat_nxt +: s_burst];
            if (last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        StDone: begin
          resp_o  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed self-checking bench for line_burst_adaptor: fill, writeback, stalls, priority,
// asynchronous reset mid-burst and (when enabled) critical-word-first reads.
module tb_line_burst_adaptor;

`ifdef LINE_BURST_ADAPTOR_CRIT_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  fill_beats [4];
  logic [255:0] fill_line;

  line_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd_addr(input logic [31:0] a);
    return Cwf ? (a & 32'hFFFF_FFF8) : (a & 32'hFFFF_FFE0);
  endfunction

  function automatic int start_beat(input logic [31:0] a);
    return Cwf ? int'((a >> 3) & 32'd3) : 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    step();
    step();
    n_tests++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {read_o, write_o, resp_o});
    end
    n_tests++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      n_fail++; $display("FAIL reset_data: line_o %h burst_o %h address_o %h want all 0",
                         line_o, burst_o, address_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    int edges;
    int hi;
    int st;
    fill_beats[0] = {4{16'h1111}};
    fill_beats[1] = {4{16'h2222}};
    fill_beats[2] = {4{16'h3333}};
    fill_beats[3] = {4{16'h4444}};
    fill_line = {fill_beats[3], fill_beats[2], fill_beats[1], fill_beats[0]};
    st = start_beat(32'h0000_1234);
    read_i = 1'b1; address_i = 32'h0000_1234; resp_i = 1'b0;
    step();
    edges = 1;
    n_tests++;
    if (address_o !== exp_rd_addr(32'h0000_1234)) begin
      n_fail++; $display("FAIL fill_address: got %h want %h", address_o,
                         exp_rd_addr(32'h0000_1234));
    end
    n_tests++;
    if (write_o !== 1'b0) begin
      n_fail++; $display("FAIL fill_write_o: got %b want 0", write_o);
    end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      burst_i = fill_beats[(st + i) % 4];
      resp_i  = 1'b1;
      if (read_o === 1'b1) hi++;
      step();
      edges++;
    end
    resp_i = 1'b0; burst_i = '0;
    n_tests++;
    if (hi != 4) begin
      n_fail++; $display("FAIL fill_read_o_cycles: got %0d want 4", hi);
    end
    n_tests++;
    if (read_o !== 1'b0 || resp_o !== 1'b1) begin
      n_fail++; $display("FAIL fill_done: read_o %b resp_o %b want 0 1", read_o, resp_o);
    end
    n_tests++;
    if (edges + 1 != 6) begin
      n_fail++; $display("FAIL fill_latency: got %0d want 6", edges + 1);
    end
    n_tests++;
    if (line_o !== fill_line) begin
      n_fail++; $display("FAIL fill_line: got %h want %h", line_o, fill_line);
    end
    read_i = 1'b0;
    step();
    n_tests++;
    if (resp_o !== 1'b0 || line_o !== fill_line) begin
      n_fail++; $display("FAIL fill_after: resp_o %b line_o %h want 0 %h",
                         resp_o, line_o, fill_line);
    end
  endtask

  task automatic test_writeback();
    logic [63:0] d [4];
    d[0] = {4{16'hD0D0}}; d[1] = {4{16'hD1D1}}; d[2] = {4{16'hD2D2}}; d[3] = {4{16'hD3D3}};
    line_i = {d[3], d[2], d[1], d[0]};
    address_i = 32'h0000_ABCD; write_i = 1'b1; resp_i = 1'b0;
    step();
    n_tests++;
    if (write_o !== 1'b1 || read_o !== 1'b0) begin
      n_fail++; $display("FAIL wb_start: write_o %b read_o %b want 1 0", write_o, read_o);
    end
    n_tests++;
    if (address_o !== 32'h0000_ABC0) begin
      n_fail++; $display("FAIL wb_address: got %h want 0000abc0", address_o);
    end
    line_i = '1; address_i = 32'h0;
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (burst_o !== d[i] || write_o !== 1'b1) begin
        n_fail++; $display("FAIL wb_beat%0d: burst_o %h write_o %b want %h 1",
                           i, burst_o, write_o, d[i]);
      end
      step();
    end
    resp_i = 1'b0;
    n_tests++;
    if (write_o !== 1'b0 || resp_o !== 1'b1) begin
      n_fail++; $display("FAIL wb_done: write_o %b resp_o %b want 0 1", write_o, resp_o);
    end
    n_tests++;
    if (line_o !== fill_line) begin
      n_fail++; $display("FAIL wb_line_o_kept: got %h want %h", line_o, fill_line);
    end
    // write_i still high in DONE must not start a second writeback
    step();
    write_i = 1'b0;
    n_tests++;
    if (resp_o !== 1'b0 || write_o !== 1'b0) begin
      n_fail++; $display("FAIL wb_no_reaccept: resp_o %b write_o %b want 0 0", resp_o, write_o);
    end
    n_tests++;
    if (address_o !== 32'h0000_ABC0) begin
      n_fail++; $display("FAIL wb_address_hold: got %h want 0000abc0", address_o);
    end
    step();
  endtask

  task automatic test_stalls();
    logic        pat [7];
    logic [63:0] b [4];
    int k;
    int hi;
    int early;
    int st;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    b[0] = {4{16'hA0A0}}; b[1] = {4{16'hA1A1}}; b[2] = {4{16'hA2A2}}; b[3] = {4{16'hA3A3}};
    st = start_beat(32'h0000_1234);
    read_i = 1'b1; address_i = 32'h0000_1234; resp_i = 1'b0;
    step();
    k = 0; hi = 0; early = 0;
    for (int i = 0; i < 7; i++) begin
      resp_i = pat[i];
      burst_i = pat[i] ? b[(st + k) % 4] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) k++;
      if (read_o === 1'b1) hi++;
      if (resp_o !== 1'b0) early++;
      step();
    end
    resp_i = 1'b0;
    n_tests++;
    if (hi != 7 || early != 0) begin
      n_fail++; $display("FAIL stall_hold: read_o high %0d early resp %0d want 7 0", hi, early);
    end
    n_tests++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_done: resp_o %b read_o %b want 1 0", resp_o, read_o);
    end
    n_tests++;
    if (line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_fail++; $display("FAIL stall_line: got %h want %h", line_o, {b[3], b[2], b[1], b[0]});
    end
    read_i = 1'b0;
    step();
  endtask

  task automatic test_priority();
    logic [63:0] r [4];
    r[0] = {4{16'h5050}}; r[1] = {4{16'h5151}}; r[2] = {4{16'h5252}}; r[3] = {4{16'h5353}};
    line_i = {{4{16'hC3C3}}, {4{16'hC2C2}}, {4{16'hC1C1}}, {4{16'hC0C0}}};
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_2044; resp_i = 1'b0;
    step();
    n_tests++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== {4{16'hC0C0}}) begin
      n_fail++; $display("FAIL prio_write_first: write_o %b read_o %b burst_o %h want 1 0 %h",
                         write_o, read_o, burst_o, {4{16'hC0C0}});
    end
    resp_i = 1'b1;
    repeat (4) step();
    resp_i = 1'b0; write_i = 1'b0;
    n_tests++;
    if (resp_o !== 1'b1) begin
      n_fail++; $display("FAIL prio_wb_resp: got %b want 1", resp_o);
    end
    step();
    n_tests++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      n_fail++; $display("FAIL prio_done_idle: read_o %b resp_o %b want 0 0", read_o, resp_o);
    end
    step();
    n_tests++;
    if (read_o !== 1'b1 || address_o !== exp_rd_addr(32'h0000_2044)) begin
      n_fail++; $display("FAIL prio_read_next: read_o %b address_o %h want 1 %h",
                         read_o, address_o, exp_rd_addr(32'h0000_2044));
    end
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_i = r[i];
      step();
    end
    resp_i = 1'b0;
    n_tests++;
    if (resp_o !== 1'b1 || line_o !== {r[3], r[2], r[1], r[0]}) begin
      n_fail++; $display("FAIL prio_read_line: resp_o %b line_o %h want 1 %h",
                         resp_o, line_o, {r[3], r[2], r[1], r[0]});
    end
    read_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [63:0] n [4];
    n[0] = {4{16'h7070}}; n[1] = {4{16'h7171}}; n[2] = {4{16'h7272}}; n[3] = {4{16'h7373}};
    read_i = 1'b1; address_i = 32'h0000_1234; resp_i = 1'b0;
    step();
    resp_i = 1'b1;
    burst_i = {4{16'h9999}};
    step();
    burst_i = {4{16'h8888}};
    step();
    resp_i = 1'b0; read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== '0 || address_o !== '0) begin
      n_fail++; $display("FAIL rst_mid: read_o %b resp_o %b line_o %h address_o %h want 0",
                         read_o, resp_o, line_o, address_o);
    end
    step();
    rst = 1'b0;
    step();
    read_i = 1'b1; address_i = 32'h0000_0040;
    step();
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_i = n[i];
      if (i == 3) begin
        n_tests++;
        if (resp_o !== 1'b0) begin
          n_fail++; $display("FAIL rst_early_resp: got %b want 0", resp_o);
        end
      end
      step();
    end
    resp_i = 1'b0;
    n_tests++;
    if (resp_o !== 1'b1 || line_o !== {n[3], n[2], n[1], n[0]}) begin
      n_fail++; $display("FAIL rst_new_read: resp_o %b line_o %h want 1 %h",
                         resp_o, line_o, {n[3], n[2], n[1], n[0]});
    end
    read_i = 1'b0;
    step();
  endtask

`ifdef LINE_BURST_ADAPTOR_CRIT_WORD_FIRST_EN
  task automatic test_crit_word();
    logic [63:0] c [4];
    c[0] = {4{16'hB0B0}}; c[1] = {4{16'hB1B1}}; c[2] = {4{16'hB2B2}}; c[3] = {4{16'hB3B3}};
    read_i = 1'b1; address_i = 32'h0000_1234; resp_i = 1'b0;
    step();
    n_tests++;
    if (address_o !== 32'h0000_1230) begin
      n_fail++; $display("FAIL cwf_address: got %h want 00001230", address_o);
    end
    resp_i = 1'b1;
    burst_i = c[2]; step();
    burst_i = c[3]; step();
    burst_i = c[0]; step();
    burst_i = c[1]; step();
    resp_i = 1'b0;
    n_tests++;
    if (resp_o !== 1'b1 || line_o !== {c[3], c[2], c[1], c[0]}) begin
      n_fail++; $display("FAIL cwf_line: resp_o %b line_o %h want 1 %h",
                         resp_o, line_o, {c[3], c[2], c[1], c[0]});
    end
    read_i = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_stalls();
    test_priority();
    test_reset_mid();
`ifdef LINE_BURST_ADAPTOR_CRIT_WORD_FIRST_EN
    test_crit_word();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
